icache_dm: RTL
==============

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (imem_*) and a 64-bit burst memory port (bmem_*).
- Converts single-word fetch requests into 4-beat line fills (32-byte lines).
- Returns hits with one-cycle latency.
- Supports a whole-cache invalidate (flush) for fence.i.

Parameters:
SETS, 16, number of lines; power of two, >=2; index width IW = log2(SETS)
LINE_BEATS, 4, 64-bit beats per line (fixed; line = 256 bits)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
imem_read  in  1  fetch request; held with imem_address stable until imem_resp
imem_address  in  32  byte address; bits [1:0] ignored
imem_rdata  out  32  fetched word; valid only while imem_resp=1
imem_resp  out  1  one-cycle completion pulse
flush  in  1  invalidate all lines
bmem_read  out  1  burst read request; held until bmem_ready
bmem_addr  out  32  line-aligned address ([4:0]=0)
bmem_ready  in  1  memory accepted the burst request
bmem_rvalid  in  1  one 64-bit beat valid
bmem_rdata  in  64  beat data; beat b = line bytes 8b..8b+7, little-endian

Behaviour:
- Address split: offset [4:0], word select [4:2], index [IW+4:5], tag [31:IW+5].
- Storage: per set, a valid bit, a tag, and 256 data bits, all in flops.
- Reset:
  - FSM -> IDLE; all valid bits cleared; beat counter = 0.
  - imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0.
  - Reset mid-fill abandons the burst. Any late bmem_rvalid is ignored in IDLE.
- FSM states: IDLE, LOOKUP, MISS_REQ, FILL, RESP.
- IDLE:
  - flush=1: clear all valid bits this cycle; the request is not sampled this cycle.
  - Otherwise, imem_read=1: latch the address into req_addr and go to LOOKUP.
- LOOKUP:
  - Hit (valid[idx] && tag match): imem_resp=1, imem_rdata = word[req_addr[4:2]] of the line; next state IDLE.
  - Miss: next state MISS_REQ.
- MISS_REQ:
  - Drive bmem_read=1 and bmem_addr = {req_addr[31:5], 5'b0}.
  - On bmem_ready=1: go to FILL with beat=0. bmem_read drops the following cycle.
- FILL:
  - Each cycle with bmem_rvalid=1: write bmem_rdata into beat slot [beat] of the line buffer, then beat++.
  - On the cycle that accepts beat LINE_BEATS-1: write tag and data into set idx, set valid, go to RESP.
  - Cycles without rvalid: no change.
- RESP: imem_resp=1, imem_rdata = requested word from the filled line; next state IDLE.
- Latency:
  - Hit: imem_resp is asserted 1 cycle after the request is sampled in IDLE. Throughput is 1 fetch per 2 cycles.
  - Miss: 2 + (cycles to bmem_ready) + (cycles to 4th rvalid) + 1.
- imem_read still high in IDLE after a resp is treated as a new request.
- imem_read dropped mid-miss: the fill still completes and installs the line; RESP pulse still occurs and may be ignored.
- flush outside IDLE is deferred (latched pending) and applied on the next IDLE cycle before any new request is sampled.
- A fill in progress when the flush is latched still installs its line, then the pending flush clears it.
- bmem_rvalid outside FILL is ignored.
- A fill that conflicts with a valid line (same index, different tag) overwrites it; no writeback is needed (read-only cache).
- Only one outstanding burst at a time.

Test Plan:
- Cold miss:
  - Stimulus: reset; read 0x0000_1004; bmem_ready after 2 cycles; rvalid beats 0x1111_1111_0000_0000, 0x3333_3333_2222_2222, ...
  - Required: bmem_addr=0x0000_1000; imem_rdata=0x1111_1111; exactly one resp pulse.
- Hit after fill:
  - Stimulus: read 0x0000_101C.
  - Required: no bmem_read; imem_resp one cycle after sampling; rdata = upper half of beat 3.
- Conflict eviction (SETS=16):
  - Stimulus: read 0x0000_1000, then 0x0000_1200 (same index 0, different tag), then 0x0000_1000 again.
  - Required: three fills, each with correct data.
- Gapped fill:
  - Stimulus: insert 3 idle cycles between rvalid beats 1 and 2.
  - Required: beat counter holds during the gap; line is correct; resp appears 1 cycle after the 4th beat.
- Flush:
  - Stimulus: fill a line; assert flush during a second fill; then re-read the first address.
  - Required: a miss (bmem_read=1) on the re-read.
- Reset mid-fill:
  - Stimulus: assert rst after 2 beats, then issue rvalid pulses.
  - Required: FSM in IDLE, outputs zero, stray beats ignored; next read of the same address misses.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache: single-word fetches in front of a
// 64-bit burst memory. Lines are 32 bytes and are filled as 4-beat bursts.
module icache_dm #(
  parameter int SETS       = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic [31:0] imem_address,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic        flush,
  output logic        bmem_read,
  output logic [31:0] bmem_addr,
  input  logic        bmem_ready,
  input  logic        bmem_rvalid,
  input  logic [63:0] bmem_rdata
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - 5;
  localparam int BW = $clog2(LINE_BEATS);
  localparam int LW = LINE_BEATS * 64;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESP} state_t;

  state_t          state;
  logic [31:0]     req_addr;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags  [SETS];
  logic [LW-1:0]   lines [SETS];
  logic [LW-1:0]   line_buf;
  logic [LW-1:0]   fill_line;
  logic [BW-1:0]   beat;
  logic            flush_pending;
  logic            lookup_hit;

  logic [IW-1:0]   in_idx;
  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   in_tag;
  logic [LW-1:0]   in_line;
  logic            in_hit;
  logic            install;
  logic            unused_bits;

  assign in_idx      = imem_address[IW+4:5];
  assign in_tag      = imem_address[31:IW+5];
  assign req_idx     = req_addr[IW+4:5];
  assign in_line     = lines[in_idx];
  assign in_hit      = valid[in_idx] && (tags[in_idx] == in_tag);
  assign install     = (state == FILL) && bmem_rvalid && (beat == BW'(LINE_BEATS - 1));
  assign unused_bits = ^{imem_address[1:0], req_addr[1:0]};

  // Line as it looks once the beat arriving this cycle is merged in.
  always_comb begin
    fill_line = line_buf;
    fill_line[{beat, 6'b0} +: 64] = bmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (install) begin
      lines[req_idx] <= fill_line;
      tags[req_idx]  <= req_addr[31:IW+5];
    end
  end

  // Hit detection happens at the sampling edge so the response is registered
  // and visible during LOOKUP, one cycle after the request is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      beat          <= '0;
      req_addr      <= '0;
      flush_pending <= 1'b0;
      lookup_hit    <= 1'b0;
      imem_resp     <= 1'b0;
      imem_rdata    <= '0;
      bmem_read     <= 1'b0;
      bmem_addr     <= '0;
    end else begin
      imem_resp <= 1'b0;
      if (flush && state != IDLE) flush_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (flush || flush_pending) begin
            valid         <= '0;
            flush_pending <= 1'b0;
          end else if (imem_read) begin
            req_addr   <= imem_address;
            lookup_hit <= in_hit;
            state      <= LOOKUP;
            if (in_hit) begin
              imem_resp  <= 1'b1;
              imem_rdata <= in_line[{imem_address[4:2], 5'b0} +: 32];
            end
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            state <= IDLE;
          end else begin
            state     <= MISS_REQ;
            bmem_read <= 1'b1;
            bmem_addr <= {req_addr[31:5], 5'b0};
          end
        end
        MISS_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            beat      <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (bmem_rvalid) begin
            line_buf[{beat, 6'b0} +: 64] <= bmem_rdata;
            beat <= beat + 1'b1;
            if (install) begin
              valid[req_idx] <= 1'b1;
              imem_resp      <= 1'b1;
              imem_rdata     <= fill_line[{req_addr[4:2], 5'b0} +: 32];
              state          <= RESP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
